uart_rx_pkt_ctrl: RTL and testbench

- Packet-level controller downstream of the UART byte receiver.
- Consumes the receiver's one-cycle `rx_d` strobe and `rx_rec` byte, and hunts for a sync byte.
- Parses address/length/payload/checksum into an internal buffer and, only after the checksum verifies, replays the payload as addressed register writes over a valid/ready port.
- Malformed, stalled or overrun packets are discarded and flagged by error pulses.

---
 rtl/uart_rx_pkt_ctrl.sv | 157 +++++++++++++++
 tb/tb_uart_rx_pkt_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_pkt_ctrl.sv
// rtl/uart_rx_pkt_ctrl.sv - UART packet parser: sync hunt, checksum verify, buffered register-write replay
module uart_rx_pkt_ctrl #(
    parameter int MAX_LEN     = 16,
    parameter int TIMEOUT_CYC = 105600
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_d,
    input  logic [7:0] rx_rec,
    input  logic       wr_ready,
    output logic       wr_valid,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       wr_last,
    output logic       busy,
    output logic       pkt_ok,
    output logic       chk_err,
    output logic       len_err,
    output logic       to_err,
    output logic       ovf_err
);
    localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYC - 1);
    localparam logic [7:0]    SYNC      = 8'hA5;
    localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);

    typedef enum logic [2:0] {S_HUNT, S_ADDR, S_LEN, S_PAYLOAD, S_CHK, S_DRAIN} state_t;

    state_t        state_q, state_d;
    logic [7:0]    addr_q, addr_d, len_q, len_d, idx_q, idx_d, xor_q, xor_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic          pkt_ok_q, pkt_ok_d, chk_err_q, chk_err_d, len_err_q, len_err_d;
    logic          to_err_q, to_err_d, ovf_err_q, ovf_err_d;
    logic          mem_we;
    logic          counting;
    logic [7:0]    mem_q [MAX_LEN];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_HUNT;
            addr_q    <= '0;
            len_q     <= '0;
            idx_q     <= '0;
            xor_q     <= '0;
            cnt_q     <= '0;
            pkt_ok_q  <= 1'b0;
            chk_err_q <= 1'b0;
            len_err_q <= 1'b0;
            to_err_q  <= 1'b0;
            ovf_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            xor_q     <= xor_d;
            cnt_q     <= cnt_d;
            pkt_ok_q  <= pkt_ok_d;
            chk_err_q <= chk_err_d;
            len_err_q <= len_err_d;
            to_err_q  <= to_err_d;
            ovf_err_q <= ovf_err_d;
        end
    end

    // Payload buffer has no reset; contents are only read after being written.
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[idx_q[IW-1:0]] <= rx_rec;
    end

    assign counting = (state_q == S_ADDR) || (state_q == S_LEN) ||
                      (state_q == S_PAYLOAD) || (state_q == S_CHK);

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        len_d     = len_q;
        idx_d     = idx_q;
        xor_d     = xor_q;
        cnt_d     = (counting && !rx_d) ? cnt_q + 1'b1 : '0;
        pkt_ok_d  = 1'b0;
        chk_err_d = 1'b0;
        len_err_d = 1'b0;
        to_err_d  = 1'b0;
        ovf_err_d = 1'b0;
        mem_we    = 1'b0;
        case (state_q)
            S_HUNT: if (rx_d && rx_rec == SYNC) state_d = S_ADDR;
            S_ADDR: if (rx_d) begin
                addr_d  = rx_rec;
                xor_d   = rx_rec;
                state_d = S_LEN;
            end
            S_LEN: if (rx_d) begin
                if (rx_rec == 8'd0 || rx_rec > MAX_LEN_B) begin
                    len_err_d = 1'b1;
                    state_d   = S_HUNT;
                end else begin
                    len_d   = rx_rec;
                    xor_d   = xor_q ^ rx_rec;
                    idx_d   = '0;
                    state_d = S_PAYLOAD;
                end
            end
            S_PAYLOAD: if (rx_d) begin
                mem_we = 1'b1;
                xor_d  = xor_q ^ rx_rec;
                if (idx_q == len_q - 8'd1) begin
                    idx_d   = '0;
                    state_d = S_CHK;
                end else begin
                    idx_d = idx_q + 8'd1;
                end
            end
            S_CHK: if (rx_d) begin
                if (rx_rec == xor_q) begin
                    pkt_ok_d = 1'b1;
                    state_d  = S_DRAIN;
                end else begin
                    chk_err_d = 1'b1;
                    state_d   = S_HUNT;
                end
            end
            S_DRAIN: begin
                ovf_err_d = rx_d;
                if (wr_ready) begin
                    if (idx_q == len_q - 8'd1) begin
                        idx_d   = '0;
                        state_d = S_HUNT;
                    end else begin
                        idx_d = idx_q + 8'd1;
                    end
                end
            end
            default: state_d = S_HUNT;
        endcase
        // Timeout only fires on an idle terminal cycle; a byte arriving then wins.
        if (counting && !rx_d && cnt_q == TO_LAST) begin
            to_err_d = 1'b1;
            state_d  = S_HUNT;
        end
    end

    always_comb begin
        wr_valid = (state_q == S_DRAIN);
        wr_addr  = wr_valid ? addr_q + idx_q : 8'd0;
        wr_data  = wr_valid ? mem_q[idx_q[IW-1:0]] : 8'd0;
        wr_last  = wr_valid && (idx_q == len_q - 8'd1);
        busy     = (state_q != S_HUNT);
        pkt_ok   = pkt_ok_q;
        chk_err  = chk_err_q;
        len_err  = len_err_q;
        to_err   = to_err_q;
        ovf_err  = ovf_err_q;
    end
endmodule

// File: tb/tb_uart_rx_pkt_ctrl.sv
// tb/tb_uart_rx_pkt_ctrl.sv - directed scoreboard bench for uart_rx_pkt_ctrl
module tb_uart_rx_pkt_ctrl;
    localparam int TO = 40;

    logic       clk = 1'b0;
    logic       rst_n, rx_d, wr_ready;
    logic [7:0] rx_rec;
    logic       wr_valid, wr_last, busy, pkt_ok, chk_err, len_err, to_err, ovf_err;
    logic [7:0] wr_addr, wr_data;

    int tests = 0;
    int failures = 0;
    int n_pkt = 0, n_chk = 0, n_len = 0, n_to = 0, n_ovf = 0, n_wr = 0;
    logic [16:0] exp_q [$];
    logic [7:0]  pl [$];

    uart_rx_pkt_ctrl #(.MAX_LEN(16), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst_n(rst_n), .rx_d(rx_d), .rx_rec(rx_rec), .wr_ready(wr_ready),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_last(wr_last),
        .busy(busy), .pkt_ok(pkt_ok), .chk_err(chk_err), .len_err(len_err),
        .to_err(to_err), .ovf_err(ovf_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Output monitor: pulse counting, write scoreboard, stall stability against expected head.
    always @(negedge clk) begin
        if (rst_n) begin
            n_pkt += int'(pkt_ok);
            n_chk += int'(chk_err);
            n_len += int'(len_err);
            n_to  += int'(to_err);
            n_ovf += int'(ovf_err);
            chk("pulse_onehot", 32'($onehot0({pkt_ok, chk_err, len_err, to_err, ovf_err})), 32'd1);
            if (pkt_ok) chk("pkt_ok_with_valid", 32'(wr_valid), 32'd1);
            if (wr_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", {15'd0, wr_addr, wr_data, wr_last}, 32'h1FFFF);
                end else if (wr_ready) begin
                    chk("write", {15'd0, wr_addr, wr_data, wr_last}, {15'd0, exp_q.pop_front()});
                    n_wr++;
                end else begin
                    chk("stall_hold", {15'd0, wr_addr, wr_data, wr_last}, {15'd0, exp_q[0]});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_d   = 1'b1;
        rx_rec = b;
        tick();
        rx_d   = 1'b0;
    endtask

    // Sends A5, ADDR, LEN, payload from pl, CHK^bad; queues writes when the packet should verify.
    task automatic send_pkt(input logic [7:0] a, input logic [7:0] bad);
        logic [7:0] x;
        x = a ^ 8'(pl.size());
        send(8'hA5);
        send(a);
        send(8'(pl.size()));
        foreach (pl[i]) begin
            send(pl[i]);
            x = x ^ pl[i];
        end
        if (bad == 8'd0)
            foreach (pl[i]) exp_q.push_back({a + 8'(i), pl[i], i == pl.size() - 1});
        send(x ^ bad);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((busy || exp_q.size() != 0) && n < 200) begin
            tick();
            n++;
        end
        chk(tag, 32'(n < 200), 32'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        chk("reset_outputs", {22'd0, wr_valid, wr_last, busy, pkt_ok, chk_err, len_err, to_err, ovf_err,
            (wr_addr != 8'd0), (wr_data != 8'd0)}, 32'd0);
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        int p0, c0, l0, t0, o0, w0;
        rst_n = 1'b0; rx_d = 1'b0; rx_rec = 8'd0; wr_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        do_reset();

        // Good packet, zero-stall drain on consecutive cycles
        p0 = n_pkt; w0 = n_wr;
        pl = '{8'h11, 8'h22, 8'h33};
        send_pkt(8'h10, 8'h00);
        chk("t1_first_valid", {30'd0, wr_valid, pkt_ok}, 32'd3);
        tick();
        chk("t1_second_valid", {30'd0, wr_valid, wr_last}, 32'd2);
        tick();
        chk("t1_third_last", {30'd0, wr_valid, wr_last}, 32'd3);
        tick();
        chk("t1_done", {30'd0, wr_valid, busy}, 32'd0);
        chk("t1_pkt_ok", 32'(n_pkt - p0), 32'd1);
        chk("t1_writes", 32'(n_wr - w0), 32'd3);

        // Bad checksum 0x14, then recovery
        c0 = n_chk; w0 = n_wr;
        send_pkt(8'h10, 8'h07);
        tick();
        chk("t2_chk_err", 32'(n_chk - c0), 32'd1);
        chk("t2_no_write", 32'(n_wr - w0), 32'd0);
        chk("t2_hunt", 32'(busy), 32'd0);
        pl = '{8'h5C, 8'h00};
        send_pkt(8'hC0, 8'h00);
        wait_idle("t2_recover_idle");
        chk("t2_recover_writes", 32'(n_wr - w0), 32'd2);

        // Garbage then LEN=0 and LEN=17
        p0 = n_pkt; c0 = n_chk; l0 = n_len; t0 = n_to; o0 = n_ovf;
        send(8'h00); send(8'hFF); send(8'h5A);
        tick();
        chk("t3_garbage_quiet", 32'((n_pkt - p0) + (n_chk - c0) + (n_len - l0) + (n_to - t0) + (n_ovf - o0)), 32'd0);
        chk("t3_garbage_hunt", 32'(busy), 32'd0);
        send(8'hA5); send(8'h07); send(8'h00);
        tick();
        chk("t3_len0", 32'(n_len - l0), 32'd1);
        send(8'hA5); send(8'h07); send(8'h11);
        tick();
        chk("t3_len17", 32'(n_len - l0), 32'd2);
        chk("t3_hunt", 32'(busy), 32'd0);

        // Inter-byte timeout, then a byte exactly on the terminal cycle
        t0 = n_to;
        send(8'hA5); send(8'h20); send(8'h02); send(8'hAA);
        repeat (TO - 1) tick();
        chk("t4_before_to", 32'({n_to - t0, 1'b0} | 32'(!busy)), 32'd0);
        repeat (2) tick();
        chk("t4_to_err", 32'(n_to - t0), 32'd1);
        chk("t4_hunt", 32'(busy), 32'd0);
        p0 = n_pkt; w0 = n_wr;
        send(8'hA5); send(8'h20); send(8'h02); send(8'hAA);
        repeat (TO - 1) tick();
        exp_q.push_back({8'h20, 8'hAA, 1'b0});
        exp_q.push_back({8'h21, 8'hBB, 1'b1});
        send(8'hBB);
        send(8'h33);
        wait_idle("t4_idle");
        chk("t4_terminal_no_to", 32'(n_to - t0), 32'd1);
        chk("t4_terminal_pkt", 32'(n_pkt - p0), 32'd1);
        chk("t4_terminal_writes", 32'(n_wr - w0), 32'd2);

        // Stalled drain with address wrap and an overrun byte
        o0 = n_ovf; w0 = n_wr;
        wr_ready = 1'b0;
        pl = '{8'h01, 8'h02};
        send_pkt(8'hFF, 8'h00);
        repeat (5) tick();
        wr_ready = 1'b1; tick(); wr_ready = 1'b0;
        repeat (2) tick();
        send(8'hA5);
        repeat (2) tick();
        chk("t5_ovf", 32'(n_ovf - o0), 32'd1);
        chk("t5_still_draining", {30'd0, wr_valid, busy}, 32'd3);
        wr_ready = 1'b1; tick();
        chk("t5_done", {30'd0, wr_valid, busy}, 32'd0);
        chk("t5_writes", 32'(n_wr - w0), 32'd2);

        // Reset mid-payload and mid-drain
        send(8'hA5); send(8'h30); send(8'h03); send(8'h01);
        chk("t6_busy_payload", 32'(busy), 32'd1);
        do_reset();
        wr_ready = 1'b0;
        pl = '{8'h44, 8'h55, 8'h66};
        send_pkt(8'h40, 8'h00);
        tick();
        chk("t6_drain_valid", 32'(wr_valid), 32'd1);
        do_reset();
        wr_ready = 1'b1;
        p0 = n_pkt; w0 = n_wr;
        pl = '{8'h77, 8'h88};
        send_pkt(8'h50, 8'h00);
        wait_idle("t6_idle");
        chk("t6_fresh_pkt", 32'(n_pkt - p0), 32'd1);
        chk("t6_fresh_writes", 32'(n_wr - w0), 32'd2);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end
endmodule
